// File: rtl/barrel_shift_unit.sv
// -----------------------------------------------------------------------------
// barrel_shift_unit
//
// Barrel shifter for the pipelined ALU. It supports a logical left shift, a
// logical right shift and an arithmetic right shift.
//
// The core is a log shifter. It has one stage for each bit of B, and the
// stages shift by 1, 2, 4, 8 and 16. Right shifts reuse the left-shift
// stages: the operand is bit-reversed on the way in and again on the way out.
//
// Y is purely combinational and feeds the ALU result mux in the same cycle.
// Y_q, out_valid and zero_q hold a registered copy of the result. That copy
// appears one cycle later, for the pipeline register stage.
//
// Ports:
//   clk        system clock; registers update on the rising edge
//   n_rst      asynchronous active-low reset
//   A          operand to be shifted
//   B          unsigned shift amount, 0..WIDTH-1
//   SFN        op select: 00 SHL, 01 SHR, 11 SRA, 10 reserved (Y = A)
//   in_valid   qualifies A/B/SFN for capture into the output register
//   Y          combinational shift result
//   Y_q        registered result
//   out_valid  Y_q holds a result captured on the previous edge
//   zero_q     registered flag, set when the captured result is zero
// -----------------------------------------------------------------------------
module barrel_shift_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] A,
   input  logic [SHW-1:0]   B,
   input  logic [1:0]       SFN,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q,
   output logic             out_valid,
   output logic             zero_q
);

   typedef enum logic [1:0] {
      SFN_SHL = 2'b00,
      SFN_SHR = 2'b01,
      SFN_RSV = 2'b10,
      SFN_SRA = 2'b11
   } sfn_e;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = v[WIDTH-1-i];
      end
      return r;
   endfunction

   logic             is_right;
   logic             fill;
   logic [WIDTH-1:0] stg [0:SHW];

   // SFN[0] marks both right-shift ops. The reserved code 10 is bypassed at
   // the output mux below, so its value here does not matter.
   assign is_right = SFN[0];
   // The fill bit is the sign only for SRA (SFN=11). Every other op fills with 0.
   assign fill     = SFN[1] & A[WIDTH-1];

   assign stg[0]   = is_right ? bit_rev(A) : A;

   for (genvar g = 0; g < SHW; g++) begin : g_stage
      localparam int SH = 1 << g;
      // Bits vacated at the LSB end are filled here. For right shifts they
      // become the MSBs once the result is reversed again.
      assign stg[g+1] = B[g] ? {stg[g][WIDTH-1-SH:0], {SH{fill}}} : stg[g];
   end

   always_comb begin
      unique case (sfn_e'(SFN))
         SFN_SHL:          Y = stg[SHW];
         SFN_SHR, SFN_SRA: Y = bit_rev(stg[SHW]);
         default:          Y = A;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments. An asynchronous
   // reset must appear in the sensitivity list so that it takes effect
   // without waiting for a clock edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         Y_q       <= '0;
         zero_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Y_q    <= Y;
            zero_q <= (Y == '0);
         end
      end
   end

endmodule

// File: tb/tb_barrel_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_unit
//
// Self-checking bench for barrel_shift_unit. It drives a table of directed
// vectors, then constrained-random vectors checked against a behavioural
// model, then hand-written reset and hold sequences. Expected registered
// results are queued when stimulus is driven and popped after the capture edge.
// -----------------------------------------------------------------------------
module tb_barrel_shift_unit;

   localparam logic [1:0] SHL = 2'b00;
   localparam logic [1:0] SHR = 2'b01;
   localparam logic [1:0] RSV = 2'b10;
   localparam logic [1:0] SRA = 2'b11;

   logic        clk;
   logic        n_rst;
   logic [31:0] A;
   logic [4:0]  B;
   logic [1:0]  SFN;
   logic        in_valid;
   logic [31:0] Y;
   logic [31:0] Y_q;
   logic        out_valid;
   logic        zero_q;

   barrel_shift_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .A         (A),
      .B         (B),
      .SFN       (SFN),
      .in_valid  (in_valid),
      .Y         (Y),
      .Y_q       (Y_q),
      .out_valid (out_valid),
      .zero_q    (zero_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [4:0]  b;
      logic [1:0]  sfn;
      logic [31:0] y;
   } vec_t;

   typedef struct packed {
      logic        z;
      logic [31:0] y;
   } exp_t;

   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_y  = '0;
   logic        last_z  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                         input logic [1:0] sfn);
      case (sfn)
         SHL:     return a << b;
         SHR:     return a >> b;
         SRA:     return $unsigned($signed(a) >>> b);
         default: return a;
      endcase
   endfunction

   // Drive one vector between edges, check Y combinationally, then check the
   // registered outputs just after the following rising edge.
   task automatic apply(input string name, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] sfn, input logic iv, input logic [31:0] exp_y);
      exp_t e;
      @(negedge clk);
      A = a; B = b; SFN = sfn; in_valid = iv;
      #1;
      check({name, " Y"}, Y, exp_y);
      if (iv) sb.push_back('{z: (exp_y == 32'h0), y: exp_y});
      @(posedge clk);
      #1;
      check({name, " out_valid"}, {31'b0, out_valid}, {31'b0, iv});
      if (iv) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected one entry", name);
         end else begin
            e = sb.pop_front();
            check({name, " Y_q"}, Y_q, e.y);
            check({name, " zero_q"}, {31'b0, zero_q}, {31'b0, e.z});
            last_y = e.y;
            last_z = e.z;
         end
      end else begin
         check({name, " Y_q hold"}, Y_q, last_y);
         check({name, " zero_q hold"}, {31'b0, zero_q}, {31'b0, last_z});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [19];
      vecs[0]  = '{32'h0000_0001, 5'd1,  SHL, 32'h0000_0002};
      vecs[1]  = '{32'hFFFF_FFF8, 5'd28, SHL, 32'h8000_0000};
      vecs[2]  = '{32'hFFFF_FFF8, 5'd29, SHL, 32'h0000_0000};
      vecs[3]  = '{32'hFFFF_FFF8, 5'd2,  SHR, 32'h3FFF_FFFE};
      vecs[4]  = '{32'hFFFF_FFF8, 5'd3,  SRA, 32'hFFFF_FFFF};
      vecs[5]  = '{32'h7FFF_FFF8, 5'd3,  SRA, 32'h0FFF_FFFF};
      vecs[6]  = '{32'h8000_0001, 5'd0,  SHL, 32'h8000_0001};
      vecs[7]  = '{32'h8000_0001, 5'd0,  SHR, 32'h8000_0001};
      vecs[8]  = '{32'h8000_0001, 5'd0,  SRA, 32'h8000_0001};
      vecs[9]  = '{32'h8000_0001, 5'd31, SHL, 32'h8000_0000};
      vecs[10] = '{32'h8000_0001, 5'd31, SHR, 32'h0000_0001};
      vecs[11] = '{32'h8000_0001, 5'd31, SRA, 32'hFFFF_FFFF};
      vecs[12] = '{32'h8000_0001, 5'd5,  RSV, 32'h8000_0001};
      vecs[13] = '{32'h1234_5678, 5'd4,  SHR, 32'h0123_4567};
      vecs[14] = '{32'h9234_5678, 5'd4,  SRA, 32'hF923_4567};
      vecs[15] = '{32'h1234_5678, 5'd8,  SHL, 32'h3456_7800};
      vecs[16] = '{32'hA5A5_1234, 5'd16, SHL, 32'h1234_0000};
      vecs[17] = '{32'hA5A5_1234, 5'd16, SHR, 32'h0000_A5A5};
      vecs[18] = '{32'hA5A5_1234, 5'd16, SRA, 32'hFFFF_A5A5};

      A = '0; B = '0; SFN = SHL; in_valid = 1'b0;
      n_rst = 1'b1;
      #3 n_rst = 1'b0;
      #1;
      check("reset Y_q", Y_q, 32'h0);
      check("reset out_valid", {31'b0, out_valid}, 32'h0);
      check("reset zero_q", {31'b0, zero_q}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // Directed table
      for (int i = 0; i < 19; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sfn, 1'b1, vecs[i].y);
      end

      // Random vectors with in_valid toggling, so hold behaviour is covered too
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         logic [4:0]  rb;
         logic [1:0]  rs;
         logic        rv;
         ra = $urandom;
         rb = 5'($urandom_range(0, 31));
         rs = 2'($urandom_range(0, 3));
         rv = 1'($urandom_range(0, 1));
         apply($sformatf("rnd%0d", i), ra, rb, rs, rv, model(ra, rb, rs));
      end

      // Asynchronous reset between edges while out_valid=1
      apply("pre_rst", 32'h0000_0001, 5'd1, SHL, 1'b1, 32'h0000_0002);
      #2;
      n_rst = 1'b0;
      #1;
      check("async rst Y_q", Y_q, 32'h0);
      check("async rst out_valid", {31'b0, out_valid}, 32'h0);
      check("async rst zero_q", {31'b0, zero_q}, 32'h0);
      sb.delete();
      last_y = '0;
      last_z = 1'b0;

      // A pending capture during reset is discarded
      @(negedge clk);
      A = 32'hDEAD_BEEF; B = 5'd0; SFN = SHL; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("in rst out_valid", {31'b0, out_valid}, 32'h0);
      check("in rst Y_q", Y_q, 32'h0);

      // Release with in_valid=0 leaves out_valid low
      @(negedge clk);
      in_valid = 1'b0;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("post rst out_valid", {31'b0, out_valid}, 32'h0);
      check("post rst Y_q", Y_q, 32'h0);

      // First capture after release, followed by a hold with new inputs
      apply("first_cap", 32'hFFFF_FFF8, 5'd29, SHL, 1'b1, 32'h0000_0000);
      apply("hold", 32'h0000_00F0, 5'd4, SHR, 1'b0, 32'h0000_000F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/barrel_shift_unit.md
Name: barrel_shift_unit

Overview:
- 32-bit barrel shifter for the pipelined ALU, covering the logical left, logical right and arithmetic right shift ops.
- Combinational result Y feeds the ALU result mux in the same cycle.
- A registered copy (Y_q) with a valid flag and zero flag gives a 1-cycle-latency path for the pipeline register stage.
- Core is a 5-stage log shifter (shift by 1, 2, 4, 8, 16), each stage selected by one bit of B.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHW, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand to be shifted.
- B  input  SHW  shift amount, 0..31, unsigned.
- SFN  input  2  op select: 00 SHL, 01 SHR, 11 SRA, 10 reserved.
- in_valid  input  1  qualifies A/B/SFN for capture into the output register.
- Y  output  WIDTH  combinational shift result.
- Y_q  output  WIDTH  registered result.
- out_valid  output  1  Y_q holds a result captured on the previous edge.
- zero_q  output  1  registered flag, 1 when the captured result equals 0.

Behaviour:
- SHL: Y = A << B; vacated LSBs filled with 0.
- SHR: Y = A >> B; vacated MSBs filled with 0.
- SRA: Y = A >>> B; vacated MSBs filled with A[WIDTH-1].
- SFN=10 (reserved): Y = A, unshifted; no error signalled.
- B=0 for any op: Y = A.
- B=31 cases:
  - SHL gives {A[0], 31'b0}.
  - SHR gives {31'b0, A[31]}.
  - SRA gives 32 copies of A[31].
- Shift amount never exceeds 31, so no saturation logic is required.
- Y is purely combinational from A, B, SFN; it is independent of clk and n_rst.
  - Timing budget: ~2.5 ns input-to-Y after mapping.
  - No latches allowed.
- Implementation: right shifts may reuse the left-shift datapath via bit reversal, or use dedicated stages. Fill bit for right shifts is (SFN[1] & A[WIDTH-1]).
- Registered path, latency 1 cycle:
  - Rising edge with in_valid=1: Y_q <= Y, zero_q <= (Y == 0), out_valid <= 1.
  - Rising edge with in_valid=0: out_valid <= 0; Y_q and zero_q hold their values.
- Reset: n_rst low asynchronously forces Y_q = 0, zero_q = 0, out_valid = 0 immediately, regardless of clk.
  - Reset asserted mid-operation discards any pending capture.
  - The first capture after release occurs on the first rising edge with n_rst high and in_valid=1.
- Input changes between edges affect only Y; the registered outputs change only on clock edges or reset.

Test Plan:
- A=0x00000001, B=1, SFN=SHL -> Y=0x00000002; with in_valid=1, after one edge Y_q=0x00000002, out_valid=1, zero_q=0.
- A=0xFFFFFFF8, B=28, SFN=SHL -> Y=0x80000000. Also B=29 -> Y=0x00000000 and zero_q=1 after capture.
- A=0xFFFFFFF8, B=2, SFN=SHR -> Y=0x3FFFFFFE (zero fill).
- A=0xFFFFFFF8, B=3, SFN=SRA -> Y=0xFFFFFFFF (sign fill). Also A=0x7FFFFFF8, B=3, SRA -> Y=0x0FFFFFFF.
- Boundaries, with A=0x80000001:
  - B=0 for SHL, SHR and SRA -> Y=A.
  - B=31, SHL -> Y=0x80000000.
  - B=31, SHR -> Y=0x00000001.
  - B=31, SRA -> Y=0xFFFFFFFF.
  - SFN=10 -> Y=A.
- Assert n_rst low between clock edges while out_valid=1 -> Y_q=0, out_valid=0, zero_q=0 immediately. After release with in_valid=0, out_valid stays 0.
